// File: rtl/ext_access_pkg.sv
// Shared types and defaults for the external-access controller: FSM state
// encoding, default memory geometry and the load counter width rule.
package ext_access_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam int LC_W_DEF   = ADDR_W_DEF + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_IRAM = 3'd1,
    S_LOAD_DRAM = 3'd2,
    S_RUN       = 3'd3,
    S_READOUT   = 3'd4
  } state_e;

  // One extra bit so the counter can hold a full memory's worth (2^ADDR_W).
  function automatic int lc_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ext_access_ctrl_strobe_edge.sv
// Registered rising-edge detector for one host strobe. A strobe already high
// when reset releases is not reported as an edge.
module strobe_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= strobe_i;
      armed_q <= 1'b1;
    end
  end

  // armed_q is low on the first sampled cycle after reset, masking a level
  // that was held across the release.
  assign rise_o = armed_q & strobe_i & ~prev_q;

endmodule

// File: rtl/ext_access_ctrl.sv
// Host-side access controller: selects load/run/readout mode and turns
// multi-cycle host strobes into single-cycle memory accesses.
module ext_access_ctrl
  import ext_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              start_2,
  input  logic              start_3,
  input  logic              start_4,
  input  logic [ADDR_W-1:0] addr_ext,
  input  logic              iram_write_ext_1,
  input  logic              iram_write_ext_2,
  input  logic              dram_write_ext,
  input  logic              read_en_ext,
  input  logic [DATA_W-1:0] Data_in_ins,
  input  logic [DATA_W-1:0] Data_in_dram,
  output logic              iram1_we,
  output logic              iram2_we,
  output logic              dram_we,
  output logic              dram_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] iram_wdata,
  output logic [DATA_W-1:0] dram_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [DATA_W-1:0] dram_in_1,
  output logic              rd_valid,
  output logic              core_run,
  output logic [ADDR_W:0]   load_count,
  output logic              mode_err
);

  localparam int LC_W = lc_width(ADDR_W);
  localparam logic [LC_W:0] LC_MAX = {2'b01, {ADDR_W{1'b0}}};

  function automatic logic [LC_W-1:0] sat_add(input logic [LC_W-1:0] a,
                                               input logic [1:0]      inc);
    logic [LC_W:0] s;
    s = {1'b0, a} + {{(LC_W-1){1'b0}}, inc};
    if (s > LC_MAX) s = LC_MAX;
    return s[LC_W-1:0];
  endfunction

  logic e_i1, e_i2, e_dw, e_rd;

  strobe_edge u_edge_i1 (.clock(clock), .reset_n(reset_n),
                         .strobe_i(iram_write_ext_1), .rise_o(e_i1));
  strobe_edge u_edge_i2 (.clock(clock), .reset_n(reset_n),
                         .strobe_i(iram_write_ext_2), .rise_o(e_i2));
  strobe_edge u_edge_dw (.clock(clock), .reset_n(reset_n),
                         .strobe_i(dram_write_ext), .rise_o(e_dw));
  strobe_edge u_edge_rd (.clock(clock), .reset_n(reset_n),
                         .strobe_i(read_en_ext), .rise_o(e_rd));

  state_e            state_q, state_d;
  logic              iram1_we_q, iram1_we_d;
  logic              iram2_we_q, iram2_we_d;
  logic              dram_we_q, dram_we_d;
  logic              dram_re_q, dram_re_d;
  logic              re_dly_q, re_dly_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] iram_wdata_q, iram_wdata_d;
  logic [DATA_W-1:0] dram_wdata_q, dram_wdata_d;
  logic [DATA_W-1:0] dram_in_q, dram_in_d;
  logic              rd_valid_q, rd_valid_d;
  logic              core_run_q, core_run_d;
  logic [LC_W-1:0]   load_count_q, load_count_d;
  logic              mode_err_q, mode_err_d;
  logic [2:0]        n_req;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      iram1_we_q   <= 1'b0;
      iram2_we_q   <= 1'b0;
      dram_we_q    <= 1'b0;
      dram_re_q    <= 1'b0;
      re_dly_q     <= 1'b0;
      mem_addr_q   <= '0;
      iram_wdata_q <= '0;
      dram_wdata_q <= '0;
      dram_in_q    <= '0;
      rd_valid_q   <= 1'b0;
      core_run_q   <= 1'b0;
      load_count_q <= '0;
      mode_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      iram1_we_q   <= iram1_we_d;
      iram2_we_q   <= iram2_we_d;
      dram_we_q    <= dram_we_d;
      dram_re_q    <= dram_re_d;
      re_dly_q     <= re_dly_d;
      mem_addr_q   <= mem_addr_d;
      iram_wdata_q <= iram_wdata_d;
      dram_wdata_q <= dram_wdata_d;
      dram_in_q    <= dram_in_d;
      rd_valid_q   <= rd_valid_d;
      core_run_q   <= core_run_d;
      load_count_q <= load_count_d;
      mode_err_q   <= mode_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    iram1_we_d   = 1'b0;
    iram2_we_d   = 1'b0;
    dram_we_d    = 1'b0;
    dram_re_d    = 1'b0;
    re_dly_d     = dram_re_q;
    mem_addr_d   = mem_addr_q;
    iram_wdata_d = iram_wdata_q;
    dram_wdata_d = dram_wdata_q;
    dram_in_d    = dram_in_q;
    rd_valid_d   = 1'b0;
    load_count_d = load_count_q;
    mode_err_d   = mode_err_q;
    n_req = {2'b00, start} + {2'b00, start_2} + {2'b00, start_3} + {2'b00, start_4};

    unique case (state_q)
      S_IDLE: begin
        if (n_req == 3'd1) begin
          if (start)        state_d = S_RUN;
          else if (start_2) state_d = S_LOAD_IRAM;
          else if (start_3) state_d = S_LOAD_DRAM;
          else              state_d = S_READOUT;
        end else if (n_req > 3'd1) begin
          mode_err_d = 1'b1;
        end
      end
      S_LOAD_IRAM: if (!start_2) state_d = S_IDLE;
      S_LOAD_DRAM: if (!start_3) state_d = S_IDLE;
      S_RUN:       if (!start)   state_d = S_IDLE;
      S_READOUT:   if (!start_4) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE && (state_d == S_LOAD_IRAM || state_d == S_LOAD_DRAM))
      load_count_d = '0;

    // Strobe edges act only in their own mode; anywhere else they flag an error.
    if (e_i1 || e_i2) begin
      if (state_q == S_LOAD_IRAM) begin
        iram1_we_d   = e_i1;
        iram2_we_d   = e_i2;
        mem_addr_d   = addr_ext;
        iram_wdata_d = Data_in_ins;
        load_count_d = sat_add(load_count_q, {1'b0, e_i1} + {1'b0, e_i2});
      end else begin
        mode_err_d = 1'b1;
      end
    end

    if (e_dw) begin
      if (state_q == S_LOAD_DRAM) begin
        dram_we_d    = 1'b1;
        mem_addr_d   = addr_ext;
        dram_wdata_d = Data_in_dram;
        load_count_d = sat_add(load_count_q, 2'd1);
      end else begin
        mode_err_d = 1'b1;
      end
    end

    if (e_rd) begin
      if (state_q == S_READOUT) begin
        dram_re_d  = 1'b1;
        mem_addr_d = addr_ext;
      end else begin
        mode_err_d = 1'b1;
      end
    end

    // Memory returns data one cycle after dram_re; capture it the cycle after.
    if (re_dly_q) begin
      dram_in_d  = dram_rdata;
      rd_valid_d = 1'b1;
    end

    core_run_d = (state_d == S_RUN);
  end

  assign iram1_we   = iram1_we_q;
  assign iram2_we   = iram2_we_q;
  assign dram_we    = dram_we_q;
  assign dram_re    = dram_re_q;
  assign mem_addr   = mem_addr_q;
  assign iram_wdata = iram_wdata_q;
  assign dram_wdata = dram_wdata_q;
  assign dram_in_1  = dram_in_q;
  assign rd_valid   = rd_valid_q;
  assign core_run   = core_run_q;
  assign load_count = load_count_q;
  assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_ext_access_ctrl.sv
// Directed self-checking bench for ext_access_ctrl: mode entry, strobe edge
// handling, readout latency, protocol errors, reset behaviour and saturation.
module tb_ext_access_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, start_2 = 1'b0, start_3 = 1'b0, start_4 = 1'b0;
  logic [8:0]  addr_ext = '0;
  logic        iram_write_ext_1 = 1'b0, iram_write_ext_2 = 1'b0;
  logic        dram_write_ext = 1'b0, read_en_ext = 1'b0;
  logic [15:0] Data_in_ins = '0, Data_in_dram = '0;
  logic        iram1_we, iram2_we, dram_we, dram_re;
  logic [8:0]  mem_addr;
  logic [15:0] iram_wdata, dram_wdata, dram_in_1;
  logic [15:0] dram_rdata = '0;
  logic [15:0] rd_word = '0;
  logic        rd_valid, core_run, mode_err;
  logic [9:0]  load_count;

  int checks = 0;
  int errors = 0;
  int cnt_i1 = 0, cnt_i2 = 0, cnt_dw = 0, cnt_re = 0, cnt_rv = 0, overlap = 0;

  ext_access_ctrl #(.ADDR_W(9), .DATA_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
    .addr_ext(addr_ext),
    .iram_write_ext_1(iram_write_ext_1), .iram_write_ext_2(iram_write_ext_2),
    .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext),
    .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
    .iram1_we(iram1_we), .iram2_we(iram2_we), .dram_we(dram_we), .dram_re(dram_re),
    .mem_addr(mem_addr), .iram_wdata(iram_wdata), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .dram_in_1(dram_in_1), .rd_valid(rd_valid),
    .core_run(core_run), .load_count(load_count), .mode_err(mode_err)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory stand-in: data appears one cycle after dram_re.
  always @(posedge clock) if (dram_re) dram_rdata <= rd_word;

  always @(negedge clock) begin
    if (iram1_we) cnt_i1 <= cnt_i1 + 1;
    if (iram2_we) cnt_i2 <= cnt_i2 + 1;
    if (dram_we)  cnt_dw <= cnt_dw + 1;
    if (dram_re)  cnt_re <= cnt_re + 1;
    if (rd_valid) cnt_rv <= cnt_rv + 1;
    if (dram_we && dram_re) overlap <= overlap + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    start = 1'b0; start_2 = 1'b0; start_3 = 1'b0; start_4 = 1'b0;
    reset_n = 1'b0;
    tick(2);
    checks++;
    if ({iram1_we, iram2_we, dram_we, dram_re} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000", {iram1_we, iram2_we, dram_we, dram_re});
    end
    checks++;
    if ({core_run, rd_valid, mode_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {core_run, rd_valid, mode_err});
    end
    checks++;
    if (mem_addr !== 9'd0 || load_count !== 10'd0) begin
      errors++; $display("FAIL reset_addr_count got addr %0d cnt %0d exp 0 0", mem_addr, load_count);
    end
    checks++;
    if (iram_wdata !== 16'h0 || dram_wdata !== 16'h0 || dram_in_1 !== 16'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h exp 0", iram_wdata, dram_wdata, dram_in_1);
    end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_iram_load();
    int c1, c2;
    start_2 = 1'b1;
    tick(2);
    c1 = cnt_i1; c2 = cnt_i2;
    addr_ext = 9'd1; Data_in_ins = 16'h1234; iram_write_ext_1 = 1'b1;
    tick(1);
    checks++;
    if (iram1_we !== 1'b1 || mem_addr !== 9'd1 || iram_wdata !== 16'h1234) begin
      errors++; $display("FAIL iram1_write got we %b addr %0d data %h exp 1 1 1234", iram1_we, mem_addr, iram_wdata);
    end
    checks++;
    if (load_count !== 10'd1) begin
      errors++; $display("FAIL iram1_count got %0d exp 1", load_count);
    end
    tick(1);
    checks++;
    if (iram1_we !== 1'b0) begin
      errors++; $display("FAIL iram1_single_cycle got %b exp 0", iram1_we);
    end
    tick(2);
    iram_write_ext_1 = 1'b0;
    tick(2);
    checks++;
    if (cnt_i1 - c1 !== 1 || cnt_i2 - c2 !== 0) begin
      errors++; $display("FAIL iram1_pulses got %0d/%0d exp 1/0", cnt_i1 - c1, cnt_i2 - c2);
    end
    start_2 = 1'b0;
    tick(2);
    // second session: count clears on entry, dual write counts two
    start_2 = 1'b1;
    tick(2);
    checks++;
    if (load_count !== 10'd0) begin
      errors++; $display("FAIL iram_count_clear got %0d exp 0", load_count);
    end
    addr_ext = 9'd5; Data_in_ins = 16'hABCD;
    iram_write_ext_1 = 1'b1; iram_write_ext_2 = 1'b1;
    tick(1);
    checks++;
    if ({iram1_we, iram2_we} !== 2'b11 || mem_addr !== 9'd5 || iram_wdata !== 16'hABCD || load_count !== 10'd2) begin
      errors++; $display("FAIL iram_dual got we %b addr %0d data %h cnt %0d exp 11 5 abcd 2",
                         {iram1_we, iram2_we}, mem_addr, iram_wdata, load_count);
    end
    iram_write_ext_1 = 1'b0; iram_write_ext_2 = 1'b0;
    start_2 = 1'b0;
    tick(2);
    checks++;
    if (mode_err !== 1'b0) begin
      errors++; $display("FAIL iram_no_err got %b exp 0", mode_err);
    end
  endtask

  task automatic test_dram_load();
    int cd, c1, c2;
    start_3 = 1'b1;
    tick(2);
    cd = cnt_dw; c1 = cnt_i1; c2 = cnt_i2;
    for (int i = 1; i <= 3; i++) begin
      addr_ext = 9'(i); Data_in_dram = 16'(4 + i); dram_write_ext = 1'b1;
      tick(1);
      checks++;
      if (dram_we !== 1'b1 || mem_addr !== 9'(i) || dram_wdata !== 16'(4 + i)) begin
        errors++; $display("FAIL dram_write%0d got we %b addr %0d data %h exp 1 %0d %h",
                           i, dram_we, mem_addr, dram_wdata, i, 16'(4 + i));
      end
      dram_write_ext = 1'b0;
      tick(1);
    end
    tick(1);
    checks++;
    if (load_count !== 10'd3 || cnt_dw - cd !== 3 || cnt_i1 - c1 !== 0 || cnt_i2 - c2 !== 0) begin
      errors++; $display("FAIL dram_totals got cnt %0d dw %0d i1 %0d i2 %0d exp 3 3 0 0",
                         load_count, cnt_dw - cd, cnt_i1 - c1, cnt_i2 - c2);
    end
    start_3 = 1'b0;
    tick(2);
  endtask

  task automatic test_readout();
    int cr, cv;
    start_4 = 1'b1;
    tick(2);
    cr = cnt_re; cv = cnt_rv;
    rd_word = 16'h00AB; addr_ext = 9'd9; read_en_ext = 1'b1;
    tick(1);
    checks++;
    if (dram_re !== 1'b1 || mem_addr !== 9'd9 || dram_we !== 1'b0) begin
      errors++; $display("FAIL read_strobe got re %b addr %0d we %b exp 1 9 0", dram_re, mem_addr, dram_we);
    end
    tick(1);
    checks++;
    if (dram_re !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL read_gap got re %b vld %b exp 0 0", dram_re, rd_valid);
    end
    tick(1);
    checks++;
    if (dram_in_1 !== 16'h00AB || rd_valid !== 1'b1) begin
      errors++; $display("FAIL read_capture got %h vld %b exp 00ab 1", dram_in_1, rd_valid);
    end
    rd_word = 16'h5555;
    tick(1);
    checks++;
    if (dram_in_1 !== 16'h00AB || rd_valid !== 1'b0) begin
      errors++; $display("FAIL read_hold got %h vld %b exp 00ab 0", dram_in_1, rd_valid);
    end
    read_en_ext = 1'b0; start_4 = 1'b0;
    tick(2);
    checks++;
    if (cnt_re - cr !== 1 || cnt_rv - cv !== 1 || mode_err !== 1'b0) begin
      errors++; $display("FAIL read_counts got re %0d vld %0d err %b exp 1 1 0", cnt_re - cr, cnt_rv - cv, mode_err);
    end
  endtask

  task automatic test_conflict();
    apply_reset();
    tick(1);
    start = 1'b1; start_3 = 1'b1;
    tick(2);
    checks++;
    if (mode_err !== 1'b1 || core_run !== 1'b0) begin
      errors++; $display("FAIL conflict got err %b run %b exp 1 0", mode_err, core_run);
    end
    start_3 = 1'b0;
    tick(1);
    // with only start left it may now enter RUN; error must stay sticky
    checks++;
    if (mode_err !== 1'b1) begin
      errors++; $display("FAIL conflict_sticky got %b exp 1", mode_err);
    end
    start = 1'b0;
    tick(2);
  endtask

  task automatic test_run_violation();
    int cd;
    apply_reset();
    tick(1);
    start = 1'b1;
    tick(1);
    checks++;
    if (core_run !== 1'b1 || mode_err !== 1'b0) begin
      errors++; $display("FAIL run_enter got run %b err %b exp 1 0", core_run, mode_err);
    end
    cd = cnt_dw;
    addr_ext = 9'd4; dram_write_ext = 1'b1;
    tick(1);
    checks++;
    if (dram_we !== 1'b0 || mode_err !== 1'b1 || core_run !== 1'b1) begin
      errors++; $display("FAIL run_write got we %b err %b run %b exp 0 1 1", dram_we, mode_err, core_run);
    end
    dram_write_ext = 1'b0;
    start = 1'b0;
    tick(1);
    checks++;
    if (core_run !== 1'b0 || cnt_dw - cd !== 0) begin
      errors++; $display("FAIL run_exit got run %b dw %0d exp 0 0", core_run, cnt_dw - cd);
    end
    // back in IDLE: a fresh load request must be honoured
    start_2 = 1'b1;
    tick(2);
    addr_ext = 9'd2; iram_write_ext_1 = 1'b1;
    tick(1);
    checks++;
    if (iram1_we !== 1'b1 || mem_addr !== 9'd2) begin
      errors++; $display("FAIL run_then_idle got we %b addr %0d exp 1 2", iram1_we, mem_addr);
    end
    iram_write_ext_1 = 1'b0; start_2 = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    int cd;
    apply_reset();
    tick(1);
    start_3 = 1'b1;
    tick(2);
    addr_ext = 9'd7; Data_in_dram = 16'h0003; dram_write_ext = 1'b1;
    tick(1);
    checks++;
    if (dram_we !== 1'b1 || load_count !== 10'd1) begin
      errors++; $display("FAIL mid_pre got we %b cnt %0d exp 1 1", dram_we, load_count);
    end
    reset_n = 1'b0;
    tick(1);
    checks++;
    if ({dram_we, mode_err, core_run, rd_valid} !== 4'b0000 || load_count !== 10'd0 ||
        mem_addr !== 9'd0 || dram_wdata !== 16'h0) begin
      errors++; $display("FAIL mid_reset got flags %b cnt %0d addr %0d data %h exp 0000 0 0 0",
                         {dram_we, mode_err, core_run, rd_valid}, load_count, mem_addr, dram_wdata);
    end
    cd = cnt_dw;
    reset_n = 1'b1;
    tick(4);
    checks++;
    if (cnt_dw - cd !== 0 || dram_we !== 1'b0 || mode_err !== 1'b0 || load_count !== 10'd0) begin
      errors++; $display("FAIL mid_release got dw %0d we %b err %b cnt %0d exp 0 0 0 0",
                         cnt_dw - cd, dram_we, mode_err, load_count);
    end
    dram_write_ext = 1'b0; start_3 = 1'b0;
    tick(2);
  endtask

  task automatic test_saturation();
    apply_reset();
    tick(1);
    start_3 = 1'b1;
    tick(2);
    for (int i = 0; i < 514; i++) begin
      addr_ext = 9'(i); dram_write_ext = 1'b1;
      tick(1);
      dram_write_ext = 1'b0;
      tick(1);
    end
    checks++;
    if (load_count !== 10'd512) begin
      errors++; $display("FAIL saturate got %0d exp 512", load_count);
    end
    start_3 = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_iram_load();
    test_dram_load();
    test_readout();
    test_conflict();
    test_run_violation();
    test_reset_mid();
    test_saturation();
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL we_re_overlap got %0d exp 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
